contador_bcd3: RTL and testbench

CONTADOR_BCD3 -- requirements
Module: contador_bcd3

---
 rtl/contador_bcd3_pkg.sv | 15 +
 rtl/contador_bcd3_digit.sv | 42 ++++
 rtl/contador_bcd3.sv | 66 ++++++
 tb/tb_contador_bcd3.sv | 125 ++++++++++++
 4 files changed

// File: rtl/contador_bcd3_pkg.sv
// Shared constants for the three-digit BCD counter.
//   DIGIT_W    : width of one BCD digit
//   DIGIT_MAX  : largest legal digit value
//   NUM_DIGITS : number of digits in the counter
//   bcd_sat()  : clamps a nibble to the legal BCD range
package contador_bcd3_pkg;
  localparam int DIGIT_W    = 4;
  localparam int DIGIT_MAX  = 9;
  localparam int NUM_DIGITS = 3;

  // Out-of-range nibbles (A..F) become 9; legal nibbles pass unchanged.
  function automatic logic [DIGIT_W-1:0] bcd_sat(input logic [DIGIT_W-1:0] v);
    return (v > DIGIT_W'(DIGIT_MAX)) ? DIGIT_W'(DIGIT_MAX) : v;
  endfunction
endpackage

// File: rtl/contador_bcd3_digit.sv
// One up/down BCD digit.
//   clk, reset : clock, synchronous active-high reset
//   clr, load  : synchronous clear / parallel load (ld_val already sanitised)
//   en         : step this digit one position in direction up
//   q          : registered digit value
//   term       : digit sits at its terminal value for the current direction
//                (9 going up, 0 going down); used to chain into the next digit
module bcd_digit
  import contador_bcd3_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               en,
  input  logic               up,
  output logic [DIGIT_W-1:0] q,
  output logic               term
);
  localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(DIGIT_MAX);

  logic [DIGIT_W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr)       q_d = '0;
    else if (load) q_d = ld_val;
    else if (en) begin
      if (up) q_d = (q_q >= MAX)   ? '0  : q_q + DIGIT_W'(1);
      else    q_d = (q_q == '0)    ? MAX : q_q - DIGIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q    = q_q;
  assign term = up ? (q_q == MAX) : (q_q == '0);
endmodule

// File: rtl/contador_bcd3.sv
// Three-digit BCD up/down counter, 000..999.
//   WRAP       : 1 wraps at 999/000, 0 saturates there
//   clk, reset : clock, synchronous active-high reset
//   tick       : count enable pulse
//   clr, load  : synchronous clear / load from din (nibbles >9 load as 9)
//   din        : {hundreds, tens, units}
//   up         : direction, only meaningful while tick=1
//   d2, d1, d0 : registered hundreds / tens / units digits
//   carry      : combinational terminal-count pulse
module contador_bcd3
  import contador_bcd3_pkg::*;
#(
  parameter bit WRAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        clr,
  input  logic        load,
  input  logic [11:0] din,
  input  logic        up,
  output logic [3:0]  d2,
  output logic [3:0]  d1,
  output logic [3:0]  d0,
  output logic        carry
);
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] q_all;
  logic [NUM_DIGITS-1:0]              term_all;
  logic [NUM_DIGITS-1:0]              en_all;
  logic                               at_term;
  logic                               tick_eff;

  // Whole counter at 999 (up) or 000 (down).
  assign at_term = &term_all;

  // Saturating build: suppress the step that would leave the range.
  assign tick_eff = tick & (WRAP | ~at_term);

  // Ripple enable: a digit steps only when every lower digit rolls over.
  always_comb begin
    en_all[0] = tick_eff;
    for (int i = 1; i < NUM_DIGITS; i++)
      en_all[i] = en_all[i-1] & term_all[i-1];
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
      .load   (load),
      .ld_val (bcd_sat(din[g*DIGIT_W +: DIGIT_W])),
      .en     (en_all[g]),
      .up     (up),
      .q      (q_all[g]),
      .term   (term_all[g])
    );
  end

  assign d0 = q_all[0];
  assign d1 = q_all[1];
  assign d2 = q_all[2];

  // Reported in both WRAP modes; any higher-priority control kills it.
  assign carry = tick & at_term & ~(reset | clr | load);
endmodule

// File: tb/tb_contador_bcd3.sv
module tb_contador_bcd3;
  logic        clk = 1'b0;
  logic        reset, tick, clr, load, up;
  logic [11:0] din;
  logic [3:0]  w_d2, w_d1, w_d0, s_d2, s_d1, s_d0;
  logic        w_carry, s_carry;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // WRAP=1 and WRAP=0 instances share the same stimulus.
  contador_bcd3 #(.WRAP(1'b1)) dut_w (
    .clk(clk), .reset(reset), .tick(tick), .clr(clr), .load(load),
    .din(din), .up(up), .d2(w_d2), .d1(w_d1), .d0(w_d0), .carry(w_carry));

  contador_bcd3 #(.WRAP(1'b0)) dut_s (
    .clk(clk), .reset(reset), .tick(tick), .clr(clr), .load(load),
    .din(din), .up(up), .d2(s_d2), .d1(s_d1), .d0(s_d0), .carry(s_carry));

  typedef struct {
    string       name;
    logic        rst, cl, ld, tk, u;
    logic [11:0] d;
    logic [11:0] exp_cnt;
    logic        exp_c;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %03h expected %03h", name, act, exp);
  endtask

  // Drive inputs just after the falling edge so carry can be sampled before the rise.
  task automatic drive(input logic rst, cl, ld, tk, u, input logic [11:0] d);
    @(negedge clk);
    reset = rst; clr = cl; load = ld; tick = tk; up = u; din = d;
    #1;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; load = 1'b0; tick = 1'b0; up = 1'b1; din = '0;

    vecs[0]  = '{"reset",          1,0,0,0,1, 12'h000, 12'h000, 0};
    vecs[1]  = '{"load_998",       0,0,1,0,1, 12'h998, 12'h998, 0};
    vecs[2]  = '{"up_to_999",      0,0,0,1,1, 12'h000, 12'h999, 0};
    vecs[3]  = '{"wrap_up",        0,0,0,1,1, 12'h000, 12'h000, 1};
    vecs[4]  = '{"wrap_down",      0,0,0,1,0, 12'h000, 12'h999, 1};
    vecs[5]  = '{"load_100",       0,0,1,0,1, 12'h100, 12'h100, 0};
    vecs[6]  = '{"borrow_099",     0,0,0,1,0, 12'h000, 12'h099, 0};
    vecs[7]  = '{"down_098",       0,0,0,1,0, 12'h000, 12'h098, 0};
    vecs[8]  = '{"hold_up_flip",   0,0,0,0,1, 12'h000, 12'h098, 0};
    vecs[9]  = '{"load_sanitise",  0,0,1,0,1, 12'hA5F, 12'h959, 0};
    vecs[10] = '{"clr_over_tick",  0,1,0,1,1, 12'h000, 12'h000, 0};
    vecs[11] = '{"load_over_tick", 0,0,1,1,1, 12'h123, 12'h123, 0};
    vecs[12] = '{"load_436",       0,0,1,0,1, 12'h436, 12'h436, 0};
    vecs[13] = '{"up_437",         0,0,0,1,1, 12'h000, 12'h437, 0};
    vecs[14] = '{"reset_over_ld",  1,0,1,1,1, 12'h111, 12'h000, 0};
    vecs[15] = '{"load_999",       0,0,1,0,1, 12'h999, 12'h999, 0};
    vecs[16] = '{"load_at_999",    0,0,1,1,1, 12'h999, 12'h999, 0};
    vecs[17] = '{"reset_at_999",   1,0,0,1,1, 12'h000, 12'h000, 0};
    vecs[18] = '{"load_0C9",       0,0,1,0,1, 12'h0C9, 12'h099, 0};
    vecs[19] = '{"ripple_100",     0,0,0,1,1, 12'h000, 12'h100, 0};

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].cl, vecs[i].ld, vecs[i].tk, vecs[i].u, vecs[i].d);
      check({vecs[i].name, "_carry"}, {11'd0, w_carry}, {11'd0, vecs[i].exp_c});
      edge_wait();
      check({vecs[i].name, "_cnt"}, {w_d2, w_d1, w_d0}, vecs[i].exp_cnt);
    end

    // Reset then 12 up ticks -> 012 with no carry along the way.
    drive(1,0,0,0,1, 12'h000);
    edge_wait();
    check("rst_wrap0_cnt", {s_d2, s_d1, s_d0}, 12'h000);
    for (int i = 0; i < 12; i++) begin
      drive(0,0,0,1,1, 12'h000);
      check("count12_carry", {11'd0, w_carry}, 12'h000);
      edge_wait();
    end
    check("count12_cnt", {w_d2, w_d1, w_d0}, 12'h012);

    // Direction changes between ticks do not move the count.
    drive(0,0,0,0,0, 12'h000);
    edge_wait();
    drive(0,0,0,0,1, 12'h000);
    edge_wait();
    check("dir_flip_hold", {w_d2, w_d1, w_d0}, 12'h012);

    // Saturating instance at the bottom.
    drive(0,0,1,0,0, 12'h000);
    edge_wait();
    drive(0,0,0,1,0, 12'h000);
    check("sat_down_carry", {11'd0, s_carry}, 12'h001);
    edge_wait();
    check("sat_down_cnt", {s_d2, s_d1, s_d0}, 12'h000);
    check("wrap_down_cnt2", {w_d2, w_d1, w_d0}, 12'h999);

    // Saturating instance approaching and at the top.
    drive(0,0,1,0,1, 12'h998);
    edge_wait();
    drive(0,0,0,1,1, 12'h000);
    check("sat_998_carry", {11'd0, s_carry}, 12'h000);
    edge_wait();
    check("sat_999_cnt", {s_d2, s_d1, s_d0}, 12'h999);
    drive(0,0,0,1,1, 12'h000);
    check("sat_up_carry", {11'd0, s_carry}, 12'h001);
    edge_wait();
    check("sat_up_cnt", {s_d2, s_d1, s_d0}, 12'h999);
    check("wrap_up_cnt2", {w_d2, w_d1, w_d0}, 12'h000);

    drive(0,0,0,0,1, 12'h000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
